// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: collects four BCD digits after a set-time/set-alarm
// press, validates HH:MM on enter, and commits it as a time or alarm load.
module keypad_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keypad_values,
  input  logic        shift_pulse,
  input  logic        set_time_btn,
  input  logic        set_alarm_btn,
  input  logic        enter_btn,
  output logic        reset_shift,
  output logic        load_time,
  output logic        load_alarm,
  output logic [15:0] time_out,
  output logic        entry_active,
  output logic        entry_error,
  output logic [2:0]  digit_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_CHECK, S_LOAD, S_ERROR
  } state_t;

  state_t           state;
  logic             time_prev, alarm_prev, enter_prev;
  logic             target_alarm;
  logic [CNT_W-1:0] tmo_cnt;

  logic       time_edge, alarm_edge, enter_edge, restart;
  logic [2:0] count_next;

  function automatic logic hhmm_valid(input logic [15:0] v);
    logic digits_ok;
    digits_ok = (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) &&
                (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    return digits_ok && (v[15:12] <= 4'd2) &&
           !((v[15:12] == 4'd2) && (v[11:8] > 4'd3)) && (v[7:4] <= 4'd5);
  endfunction

  assign time_edge  = set_time_btn  & ~time_prev;
  assign alarm_edge = set_alarm_btn & ~alarm_prev;
  assign enter_edge = enter_btn     & ~enter_prev;

  // A mode press restarts the entry from IDLE or mid-collection only.
  assign restart    = (time_edge | alarm_edge) &&
                      ((state == S_IDLE) || (state == S_COLLECT));
  // Counts the digit arriving alongside enter, so enter sees the final count.
  assign count_next = (shift_pulse && (digit_count != 3'd4)) ?
                      digit_count + 3'd1 : digit_count;

  // NOTE: every output is a register set on the transition into the state
  // that owns it, so pulses are glitch-free and aligned with state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      target_alarm <= 1'b0;
      // Previous values start high so a button held through reset gives no edge.
      time_prev    <= 1'b1;
      alarm_prev   <= 1'b1;
      enter_prev   <= 1'b1;
      tmo_cnt      <= '0;
      reset_shift  <= 1'b0;
      load_time    <= 1'b0;
      load_alarm   <= 1'b0;
      time_out     <= 16'h0000;
      entry_active <= 1'b0;
      entry_error  <= 1'b0;
      digit_count  <= 3'd0;
    end else begin
      // NOTE: non-blocking everywhere here; defaults below make pulses one cycle.
      time_prev   <= set_time_btn;
      alarm_prev  <= set_alarm_btn;
      enter_prev  <= enter_btn;
      reset_shift <= 1'b0;
      load_time   <= 1'b0;
      load_alarm  <= 1'b0;

      if (restart) begin
        target_alarm <= ~time_edge;
        entry_error  <= 1'b0;
        state        <= S_CLEAR;
        reset_shift  <= 1'b1;
        entry_active <= 1'b1;
        digit_count  <= 3'd0;
        tmo_cnt      <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_CLEAR: begin
            digit_count <= 3'd0;
            tmo_cnt     <= '0;
            state       <= S_COLLECT;
          end
          S_COLLECT: begin
            digit_count <= count_next;
            if (enter_edge) begin
              if (count_next == 3'd4) begin
                state <= S_CHECK;
              end else begin
                state        <= S_ERROR;
                entry_error  <= 1'b1;
                reset_shift  <= 1'b1;
                entry_active <= 1'b0;
              end
            end else if (shift_pulse) begin
              tmo_cnt <= '0;
            end else if (tmo_cnt == TMO_LAST) begin
              state        <= S_IDLE;
              reset_shift  <= 1'b1;
              entry_active <= 1'b0;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          S_CHECK: begin
            entry_active <= 1'b0;
            reset_shift  <= 1'b1;
            if (hhmm_valid(keypad_values)) begin
              state      <= S_LOAD;
              time_out   <= keypad_values;
              load_time  <= ~target_alarm;
              load_alarm <= target_alarm;
            end else begin
              state       <= S_ERROR;
              entry_error <= 1'b1;
            end
          end
          S_LOAD:  state <= S_IDLE;
          S_ERROR: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus randomized entry
// sessions checked against a transaction-level HH:MM model.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] keypad_values = 16'h0000;
  logic        shift_pulse = 1'b0;
  logic        set_time_btn = 1'b0;
  logic        set_alarm_btn = 1'b0;
  logic        enter_btn = 1'b0;
  logic        reset_shift, load_time, load_alarm, entry_active, entry_error;
  logic [15:0] time_out;
  logic [2:0]  digit_count;

  int n_cmp = 0, n_fail = 0;
  int n_lt = 0, n_la = 0, exp_lt = 0, exp_la = 0;
  logic [15:0] kv = 16'h0000;
  logic [15:0] exp_time_out = 16'h0000;
  logic        exp_err = 1'b0;

  keypad_entry_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .keypad_values(keypad_values),
    .shift_pulse(shift_pulse), .set_time_btn(set_time_btn),
    .set_alarm_btn(set_alarm_btn), .enter_btn(enter_btn),
    .reset_shift(reset_shift), .load_time(load_time), .load_alarm(load_alarm),
    .time_out(time_out), .entry_active(entry_active),
    .entry_error(entry_error), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Count every load pulse so spurious loads anywhere are caught at the end.
  always @(negedge clk) begin
    if (reset_n) begin
      if (load_time)  n_lt++;
      if (load_alarm) n_la++;
      if (load_time | load_alarm) check1("load_one_hot", load_time & load_alarm, 1'b0);
    end
  end

  function automatic bit valid_hhmm(input logic [15:0] v);
    int hh, mm;
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    hh = 10 * int'(v[15:12]) + int'(v[11:8]);
    mm = 10 * int'(v[7:4]) + int'(v[3:0]);
    return (hh < 24) && (mm < 60);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_reset_shift"}, reset_shift, 1'b0);
    check1({tag, "_load_time"}, load_time, 1'b0);
    check1({tag, "_load_alarm"}, load_alarm, 1'b0);
    check16({tag, "_time_out"}, time_out, 16'h0000);
    check1({tag, "_active"}, entry_active, 1'b0);
    check1({tag, "_error"}, entry_error, 1'b0);
    check16({tag, "_count"}, 16'(digit_count), 16'd0);
  endtask

  task automatic start_entry(input bit t, input bit a);
    set_time_btn = t;
    set_alarm_btn = a;
    step();
    check1("clear_reset_shift", reset_shift, 1'b1);
    check1("clear_active", entry_active, 1'b1);
    check16("clear_count", 16'(digit_count), 16'd0);
    check1("clear_error", entry_error, 1'b0);
    set_time_btn = 1'b0;
    set_alarm_btn = 1'b0;
    kv = 16'h0000;
    keypad_values = kv;
    exp_err = 1'b0;
    step();
    check1("collect_reset_shift", reset_shift, 1'b0);
  endtask

  task automatic add_digit(input logic [3:0] d);
    kv = {kv[11:0], d};
    keypad_values = kv;
    shift_pulse = 1'b1;
    step();
    shift_pulse = 1'b0;
  endtask

  task automatic enter_entry(input bit is_alarm, input int ndig_in,
                             input bit with_digit, input logic [3:0] d);
    int ndig, cnt;
    bit ok;
    ndig = ndig_in;
    if (with_digit) begin
      kv = {kv[11:0], d};
      keypad_values = kv;
      shift_pulse = 1'b1;
      ndig++;
    end
    cnt = (ndig > 4) ? 4 : ndig;
    ok = (cnt == 4) && valid_hhmm(kv);
    enter_btn = 1'b1;
    step();
    enter_btn = 1'b0;
    shift_pulse = 1'b0;
    check16("enter_count", 16'(digit_count), 16'(cnt));
    check1("enter_no_load_time", load_time, 1'b0);
    check1("enter_no_load_alarm", load_alarm, 1'b0);
    if (cnt < 4) begin
      check1("short_error", entry_error, 1'b1);
      check1("short_reset_shift", reset_shift, 1'b1);
      check1("short_active", entry_active, 1'b0);
      exp_err = 1'b1;
      step();
    end else begin
      check1("check_active", entry_active, 1'b1);
      step();
      check1("commit_load_time", load_time, ok && !is_alarm);
      check1("commit_load_alarm", load_alarm, ok && is_alarm);
      check1("commit_reset_shift", reset_shift, 1'b1);
      check1("commit_error", entry_error, !ok);
      if (ok) begin
        exp_time_out = kv;
        if (is_alarm) exp_la++;
        else exp_lt++;
      end else begin
        exp_err = 1'b1;
      end
      check16("commit_time_out", time_out, exp_time_out);
      step();
    end
    check1("post_active", entry_active, 1'b0);
    check1("post_load_time", load_time, 1'b0);
    check1("post_load_alarm", load_alarm, 1'b0);
    check1("post_reset_shift", reset_shift, 1'b0);
    check1("post_error", entry_error, exp_err);
    check16("post_time_out", time_out, exp_time_out);
  endtask

  // Eight quiet cycles after the last digit (or after CLEAR) abandon the entry.
  task automatic wait_timeout();
    repeat (7) begin
      step();
      check1("tmo_still_active", entry_active, 1'b1);
    end
    step();
    check1("tmo_active", entry_active, 1'b0);
    check1("tmo_reset_shift", reset_shift, 1'b1);
    check1("tmo_error", entry_error, 1'b0);
    check1("tmo_load_time", load_time, 1'b0);
    check1("tmo_load_alarm", load_alarm, 1'b0);
    step();
    check1("tmo_reset_shift_end", reset_shift, 1'b0);
    check16("tmo_time_out", time_out, exp_time_out);
  endtask

  initial begin
    #12;
    check_all_zero("in_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check_all_zero("after_reset");

    // Valid time entry
    start_entry(1'b1, 1'b0);
    add_digit(4'd1); add_digit(4'd2); add_digit(4'd3); add_digit(4'd4);
    enter_entry(1'b0, 4, 1'b0, 4'd0);
    check16("time_1234", time_out, 16'h1234);

    // Alarm entry with minute tens 6 is rejected
    start_entry(1'b0, 1'b1);
    add_digit(4'd2); add_digit(4'd3); add_digit(4'd6); add_digit(4'd0);
    enter_entry(1'b1, 4, 1'b0, 4'd0);
    check1("bad_alarm_error", entry_error, 1'b1);

    // Too few digits, then the next mode press clears the error
    start_entry(1'b1, 1'b0);
    add_digit(4'd1); add_digit(4'd5);
    enter_entry(1'b0, 2, 1'b0, 4'd0);
    start_entry(1'b0, 1'b1);
    wait_timeout();

    // One digit then silence
    start_entry(1'b1, 1'b0);
    add_digit(4'd3);
    wait_timeout();

    // Both mode buttons: time wins; six digits keep the last four
    start_entry(1'b1, 1'b1);
    add_digit(4'd1); add_digit(4'd2); add_digit(4'd0);
    add_digit(4'd9); add_digit(4'd5); add_digit(4'd9);
    enter_entry(1'b0, 6, 1'b0, 4'd0);
    check16("both_time_out", time_out, 16'h0959);
    check16("both_count", 16'(digit_count), 16'd4);

    // Mode press mid-collection outranks a simultaneous enter
    start_entry(1'b1, 1'b0);
    add_digit(4'd7); add_digit(4'd7);
    set_alarm_btn = 1'b1;
    enter_btn = 1'b1;
    step();
    check1("restart_reset_shift", reset_shift, 1'b1);
    check16("restart_count", 16'(digit_count), 16'd0);
    check1("restart_active", entry_active, 1'b1);
    set_alarm_btn = 1'b0;
    enter_btn = 1'b0;
    kv = 16'h0000;
    step();
    add_digit(4'd1); add_digit(4'd2); add_digit(4'd0);
    enter_entry(1'b1, 3, 1'b1, 4'd0);
    check16("restart_alarm_time_out", time_out, 16'h1200);

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      int mode, ndig, ending, hh, mm;
      bit with_d;
      logic [3:0] dig [6];
      mode = $urandom_range(0, 2);
      ndig = $urandom_range(0, 6);
      for (int i = 0; i < 6; i++)
        dig[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
      if (ndig >= 4 && $urandom_range(0, 1) == 1) begin
        hh = $urandom_range(0, 23);
        mm = $urandom_range(0, 59);
        dig[ndig-4] = 4'(hh / 10);
        dig[ndig-3] = 4'(hh % 10);
        dig[ndig-2] = 4'(mm / 10);
        dig[ndig-1] = 4'(mm % 10);
      end
      ending = $urandom_range(0, 5);
      with_d = (ending != 0) && (ndig > 0) && ($urandom_range(0, 1) == 1);
      start_entry(mode != 1, mode != 0);
      for (int i = 0; i < ndig - int'(with_d); i++) begin
        if (i > 0) repeat ($urandom_range(0, 3)) step();
        add_digit(dig[i]);
      end
      if (ending == 0) wait_timeout();
      else enter_entry(mode == 1, ndig - int'(with_d), with_d,
                       dig[(ndig > 0) ? ndig - 1 : 0]);
    end

    // Enter and shift pulses in IDLE do nothing
    repeat (10) begin
      enter_btn = 1'($urandom_range(0, 1));
      shift_pulse = 1'($urandom_range(0, 1));
      step();
      check1("idle_ignore_active", entry_active, 1'b0);
      check1("idle_ignore_reset_shift", reset_shift, 1'b0);
    end
    enter_btn = 1'b0;
    shift_pulse = 1'b0;
    step();

    // Reset mid-collection with set_time held through release
    start_entry(1'b1, 1'b0);
    add_digit(4'd1); add_digit(4'd2); add_digit(4'd3);
    check16("pre_reset_count", 16'(digit_count), 16'd3);
    reset_n = 1'b0;
    set_time_btn = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_time_out = 16'h0000;
    exp_err = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check1("held_btn_no_entry", entry_active, 1'b0);
    enter_btn = 1'b1;
    step();
    enter_btn = 1'b0;
    step();
    step();
    check1("post_reset_load_time", load_time, 1'b0);
    check1("post_reset_load_alarm", load_alarm, 1'b0);
    check1("post_reset_active", entry_active, 1'b0);
    check16("post_reset_time_out", time_out, 16'h0000);
    set_time_btn = 1'b0;
    step();
    check1("release_no_entry", entry_active, 1'b0);

    step();
    check16("load_time_count", 16'(n_lt), 16'(exp_lt));
    check16("load_alarm_count", 16'(n_la), 16'(exp_la));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
